// File: rtl/perm_round_reg.sv
// perm_round_reg: Keccak-f[1600] round-iteration register with load/unload handshake.
// Optional macro PERM_ABORT_EN adds an abort input that drops an in-flight permutation.
module perm_round_reg #(
    parameter int X_AXIS     = 5,
    parameter int Y_AXIS     = 5,
    parameter int Z_AXIS     = 64,
    parameter int NUM_ROUNDS = 24
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
`ifdef PERM_ABORT_EN
    input  logic                                         abort,
`endif
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]    state_in,
    output logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]    a_round_in,
    input  logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]    a_iota_out,
    output logic [31:0]                                  perm_num,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]    state_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [4:0] LAST = 5'(NUM_ROUNDS - 1);

    fsm_t                                      state_q, state_n;
    logic [4:0]                                cnt_q, cnt_n;
    logic [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0] st_q, st_n;
    logic                                      abort_i;

`ifdef PERM_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // An abort in IDLE blocks the load, so the source must not see a handshake either.
    assign in_ready   = rst_n && !abort_i && (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign a_round_in = st_q;
    assign state_out  = st_q;
    assign perm_num   = {27'd0, cnt_q};

    // State, round counter and permutation state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            st_q    <= st_n;
        end
    end

    // Next-state logic: load in IDLE, one round per cycle in RUN, hold in DONE until unload.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        st_n    = st_q;
        case (state_q)
            IDLE: if (in_valid && in_ready) begin
                st_n    = state_in;
                cnt_n   = '0;
                state_n = RUN;
            end
            RUN: begin
                st_n    = a_iota_out;
                cnt_n   = (cnt_q == LAST) ? cnt_q : cnt_q + 5'd1;
                state_n = (cnt_q == LAST) ? DONE : RUN;
            end
            DONE: if (out_ready) begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
        if (abort_i && state_q != IDLE) begin
            state_n = IDLE;
            cnt_n   = '0;
            st_n    = '0;
        end
    end

endmodule

// File: doc/perm_round_reg.md
Name: perm_round_reg

Overview:
- Sequential round-iteration stage of the SHA3-256 Keccak-f[1600] permutation. Sits directly downstream of the iota step.
- Registers the iota output each cycle and feeds the registered state back to the theta input.
- Drives the round index (perm_num) to iota's round-constant lookup.
- Wraps the combinational round chain with a load/unload valid-ready handshake: one round per clock, NUM_ROUNDS rounds per permutation.

Parameters:
X_AXIS, 5, lanes along x
Y_AXIS, 5, lanes along y
Z_AXIS, 64, lane width in bits
NUM_ROUNDS, 24, rounds per permutation (legal 1..24)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  state_in holds a new state to permute
in_ready  output  1  block can accept a state
state_in  input  [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]  initial permutation state
a_round_in  output  [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]  registered state to theta input
a_iota_out  input  [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]  combinational round result from iota
perm_num  output  32  current round index to iota
out_valid  output  1  state_out holds the completed permutation
out_ready  input  1  downstream accepts state_out
state_out  output  [X_AXIS-1:0][Y_AXIS-1:0][Z_AXIS-1:0]  permuted state

Behaviour:
- Reset: rst_n sampled low at a rising clk edge gives:
  - FSM=IDLE
  - state register = 0
  - round counter = 0
  - out_valid = 0
- in_ready is forced 0 while rst_n is low. Reset mid-permutation abandons the state with no output.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&in_ready: state register <= state_in, round counter <= 0, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each edge: state register <= a_iota_out. If counter==NUM_ROUNDS-1, go to DONE and hold the counter. Otherwise counter+1.
  - DONE: out_valid=1, in_ready=0. State register and counter hold. On out_ready: go to IDLE, counter <= 0.
- a_round_in = state register, combinational, all states.
- state_out = state register. It is meaningful only while out_valid=1.
- perm_num = round counter zero-extended to 32 bits; 0 in IDLE and after reset.
- Latency:
  - Acceptance edge T loads the state.
  - Edges T+1..T+NUM_ROUNDS apply rounds 0..NUM_ROUNDS-1.
  - out_valid is high from after edge T+NUM_ROUNDS.
  - Throughput: one permutation per NUM_ROUNDS+2 cycles minimum (load + rounds + unload).
- out_valid and state_out are stable until handshake; no drop without out_ready.
- in_valid while not in IDLE is ignored; the source must hold it. No new load is accepted in the DONE→IDLE cycle; it is accepted on the next cycle.
- out_ready asserted outside DONE has no effect.
- Round counter width: 5 bits internally; never exceeds NUM_ROUNDS-1.

Optional Feature:
- Macro: PERM_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at an edge in RUN or DONE: FSM goes to IDLE, state register and counter cleared to 0, out_valid deasserted next cycle, no output produced.
  - abort in IDLE takes priority over in_valid: no load occurs.
- Undefined: port absent; behaviour exactly as above.

Test Plan:
- Zero state: state_in=0, in_valid=1 one cycle, out_ready=1 → out_valid rises 24 cycles after acceptance; state_out[0][0]=64'hF1258F7940E1DDE7 (Keccak-f[1600] of zero).
- Round index trace: during RUN, perm_num steps 0,1,...,23, one per cycle; perm_num=0 in IDLE and after unload.
- Backpressure: out_ready=0 for 10 cycles in DONE → out_valid stays 1, state_out unchanged, in_ready=0; out_ready=1 → IDLE next cycle, in_ready=1.
- Back-to-back: in_valid held high with two states (zero, then all-ones) → second accepted only after the first is unloaded; both outputs match the golden model; accepts spaced ≥26 cycles.
- Reset mid-run: rst_n low at round 10 → next cycle out_valid=0, perm_num=0, state register=0; rst_n high → in_ready=1; a fresh permutation is correct.
- PERM_ABORT_EN: abort at round 5 → IDLE next cycle, no out_valid pulse; subsequent zero-state permutation again yields lane[0][0]=64'hF1258F7940E1DDE7.
